pc_btb_gen: RTL and testbench
=============================

PC_BTB_GEN -- requirements
Module: pc_btb_gen

Interface
REQ-001 SHALL have parameter AW, default 32, PC address width (16..32).
REQ-002 SHALL have parameter INIT_PC, default 32'h0000_3000, PC value after reset.
REQ-003 SHALL have parameter EXC_PC, default 32'h0000_4180, exception handler entry.
REQ-004 SHALL have parameter BTB_DEPTH, default 8, number of BTB entries (power of two, 2..64); IW = log2(BTB_DEPTH).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  fetch advance; 0 = stall.
REQ-008 SHALL have port to_exc  input  1  exception request.
REQ-009 SHALL have port eret  input  1  exception return.
REQ-010 SHALL have port epc  input  AW  return address for eret.
REQ-011 SHALL have port redirect  input  1  execute-stage correction (mispredict or jump).
REQ-012 SHALL have port redirect_pc  input  AW  corrected fetch address.
REQ-013 SHALL have port upd_valid  input  1  resolved-branch BTB update strobe.
REQ-014 SHALL have port upd_pc  input  AW  address of the resolved branch.
REQ-015 SHALL have port upd_target  input  AW  resolved branch target.
REQ-016 SHALL have port upd_taken  input  1  resolved branch direction.
REQ-017 SHALL have port pc  output  AW  current fetch address (registered).
REQ-018 SHALL have port pred_taken  output  1  current pc predicted taken.
REQ-019 SHALL have port pred_npc  output  AW  predicted next fetch address.

Function
REQ-020 Next-pc priority, evaluated each rising edge, SHALL be: reset -> INIT_PC; to_exc -> EXC_PC; eret -> epc; redirect -> redirect_pc; en -> pred_npc; else hold.
REQ-021 to_exc, eret and redirect SHALL take effect regardless of en.
REQ-022 Sequential next address SHALL be pc + 4, truncated to AW bits (wraps to 0 from all-ones-minus-3).
REQ-023 BTB entry SHALL hold valid, tag (pc[AW-1:IW+2]), target (AW bits), 2-bit saturating counter; index = pc[IW+1:2].
REQ-024 Lookup SHALL be combinational on pc: hit = valid and tag match; pred_taken = hit and counter[1].
REQ-025 pred_npc SHALL be target when pred_taken, else pc + 4.
REQ-026 On upd_valid with matching valid entry: taken increments counter (saturate 3) and rewrites target; not-taken decrements counter (saturate 0), target kept.
REQ-027 On upd_valid with miss (invalid or tag mismatch): taken allocates/replaces entry (valid=1, new tag, target, counter=2'b10); not-taken leaves entry unchanged.
REQ-028 Update written on the edge SHALL be visible to lookup from the next cycle; same-cycle lookup of the updated index uses old contents.
REQ-029 BTB update SHALL proceed independently of en, to_exc, eret and redirect.
REQ-030 Low two pc bits SHALL be carried unmodified from redirect_pc/epc; no alignment check.

Reset
REQ-031 On reset SHALL set pc = INIT_PC, all entry valid = 0, all counters = 2'b00; targets/tags need not be cleared.
REQ-032 After reset, pred_taken = 0 and pred_npc = INIT_PC + 4 until a taken update retires.
REQ-033 Reset asserted with upd_valid SHALL discard the update.

Configuration
REQ-034 Macro PC_BTB_PREDICT_EN defined SHALL compile in the BTB and prediction per REQ-023..029.
REQ-035 Macro PC_BTB_PREDICT_EN undefined SHALL remove all BTB storage: pred_taken tied 0, pred_npc = pc + 4, upd_* ignored; REQ-020 priority unchanged.

Verification
REQ-036 Reset, en=1 for 3 cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; pred_taken=0.
REQ-037 en=1, to_exc=1 and redirect=1 (redirect_pc=0x3100) same cycle -> pc=0x4180 next cycle; en=0 with eret=1, epc=0x3020 -> pc=0x3020.
REQ-038 upd_valid, upd_pc=0x3010, upd_taken=1, upd_target=0x3200; later pc reaches 0x3010 -> pred_taken=1, pred_npc=0x3200, next pc 0x3200.
REQ-039 Then two not-taken updates at 0x3010 -> counter 2->1->0, pred_taken=0 at 0x3010; aliasing pc 0x3030 (same index, DEPTH=8) -> miss, pred_npc=0x3034.
REQ-040 en=0 for 4 cycles at pc=0x3008 with no redirect -> pc holds 0x3008; pc=32'hFFFF_FFFC, en=1 -> pc=0x0000_0000.
REQ-041 Build without PC_BTB_PREDICT_EN, repeat REQ-038 -> pred_taken=0, pc 0x3010 -> 0x3014.

Source files
------------

// File: rtl/pc_btb_gen.sv
// Fetch PC generator with a direct-mapped branch target buffer and 2-bit counters.
// Define PC_BTB_PREDICT_EN to build the BTB; without it the fetch path is purely sequential.
module pc_btb_gen #(
    parameter int          AW        = 32,
    parameter logic [31:0] INIT_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_PC    = 32'h0000_4180,
    parameter int          BTB_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          to_exc,
    input  logic          eret,
    input  logic [AW-1:0] epc,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          upd_valid,
    input  logic [AW-1:0] upd_pc,
    input  logic [AW-1:0] upd_target,
    input  logic          upd_taken,
    output logic [AW-1:0] pc,
    output logic          pred_taken,
    output logic [AW-1:0] pred_npc
);

    localparam int IW = $clog2(BTB_DEPTH);
    localparam int TW = AW - IW - 2;

    logic [AW-1:0] seq_pc;
    assign seq_pc = pc + AW'(4);

`ifdef PC_BTB_PREDICT_EN
    logic          valid_q  [BTB_DEPTH];
    logic [1:0]    ctr_q    [BTB_DEPTH];
    logic [TW-1:0] tag_q    [BTB_DEPTH];
    logic [AW-1:0] target_q [BTB_DEPTH];

    logic [IW-1:0] look_idx;
    logic [TW-1:0] look_tag;
    logic          look_hit;
    logic [IW-1:0] upd_idx;
    logic [TW-1:0] upd_tag;
    logic          upd_hit;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else
            return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    assign look_idx   = pc[IW+1:2];
    assign look_tag   = pc[AW-1:IW+2];
    assign look_hit   = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    assign pred_taken = look_hit && ctr_q[look_idx][1];
    assign pred_npc   = pred_taken ? target_q[look_idx] : seq_pc;

    assign upd_idx = upd_pc[IW+1:2];
    assign upd_tag = upd_pc[AW-1:IW+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Control state: valid bits and counters are cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= 2'b10;
            end
        end
    end

    // Data state: tags and targets are never cleared, only gated off during reset.
    always_ff @(posedge clk) begin
        if (!reset && upd_valid && upd_taken) begin
            target_q[upd_idx] <= upd_target;
            if (!upd_hit)
                tag_q[upd_idx] <= upd_tag;
        end
    end
`else
    logic unused_upd;
    assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign pred_taken = 1'b0;
    assign pred_npc   = seq_pc;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            pc <= AW'(INIT_PC);
        else if (to_exc)
            pc <= AW'(EXC_PC);
        else if (eret)
            pc <= epc;
        else if (redirect)
            pc <= redirect_pc;
        else if (en)
            pc <= pred_npc;
    end

endmodule

// File: tb/tb_pc_btb_gen.sv
// Directed self-checking bench for pc_btb_gen; expectations follow the build's PC_BTB_PREDICT_EN setting.
module tb_pc_btb_gen;

`ifdef PC_BTB_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        to_exc = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_npc;

    int checks = 0;
    int errors = 0;

    pc_btb_gen dut (
        .clk(clk), .reset(reset), .en(en), .to_exc(to_exc), .eret(eret), .epc(epc),
        .redirect(redirect), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .pc(pc), .pred_taken(pred_taken), .pred_npc(pred_npc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks pred_taken/pred_npc at the current pc; taken_if_pred applies only to the BTB build.
    task automatic chk_pred(input string tag, input logic taken_if_pred, input logic [31:0] tgt);
        logic        exp_t;
        logic [31:0] exp_n;
        exp_t = PRED & taken_if_pred;
        exp_n = exp_t ? tgt : pc + 32'd4;
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
        chk({tag, "_npc"}, pred_npc, exp_n);
    endtask

    task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tgt);
        upd_valid = 1'b1; upd_pc = a; upd_taken = t; upd_target = tgt;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic jump(input logic [31:0] a);
        redirect = 1'b1; redirect_pc = a;
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_pc", pc, 32'h3000);
        chk_pred("reset", 1'b0, 32'h0);

        en = 1'b1;
        tick(); chk("seq1", pc, 32'h3004);
        tick(); chk("seq2", pc, 32'h3008);
        tick(); chk("seq3", pc, 32'h300C);
        chk_pred("seq3", 1'b0, 32'h0);

        to_exc = 1'b1; redirect = 1'b1; redirect_pc = 32'h3100;
        tick();
        to_exc = 1'b0; redirect = 1'b0; en = 1'b0;
        chk("exc_prio", pc, 32'h4180);

        eret = 1'b1; epc = 32'h3020;
        tick();
        eret = 1'b0;
        chk("eret", pc, 32'h3020);

        jump(32'h3008);
        chk("redir", pc, 32'h3008);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold", pc, 32'h3008);
        end

        upd(32'h3010, 1'b1, 32'h3200);
        chk("upd_stall_hold", pc, 32'h3008);
        en = 1'b1;
        tick(); chk("to_300c", pc, 32'h300C);
        chk_pred("at_300c", 1'b0, 32'h0);
        tick(); chk("to_3010", pc, 32'h3010);
        chk_pred("alloc", 1'b1, 32'h3200);
        tick(); chk("after_3010", pc, PRED ? 32'h3200 : 32'h3014);
        en = 1'b0;

        jump(32'h3010);
        upd(32'h3010, 1'b0, 32'h0);  chk_pred("nt_c1", 1'b0, 32'h0);
        upd(32'h3010, 1'b0, 32'h0);  chk_pred("nt_c0", 1'b0, 32'h0);
        upd(32'h3010, 1'b1, 32'h3200); chk_pred("t_c1", 1'b0, 32'h0);
        upd(32'h3010, 1'b1, 32'h3300); chk_pred("t_c2", 1'b1, 32'h3300);
        upd(32'h3010, 1'b1, 32'h3300); chk_pred("t_c3", 1'b1, 32'h3300);
        upd(32'h3010, 1'b1, 32'h3300); chk_pred("t_c3sat", 1'b1, 32'h3300);
        upd(32'h3010, 1'b0, 32'h3900); chk_pred("nt_c2", 1'b1, 32'h3300);
        chk("btb_hold_pc", pc, 32'h3010);

        redirect = 1'b1; redirect_pc = 32'h3030;
        upd_valid = 1'b1; upd_pc = 32'h3030; upd_taken = 1'b0; upd_target = 32'h3700;
        tick();
        redirect = 1'b0; upd_valid = 1'b0;
        chk_pred("alias_miss", 1'b0, 32'h0);
        chk("alias_npc_seq", pred_npc, 32'h3034);
        jump(32'h3010);
        chk_pred("alias_nt_kept", 1'b1, 32'h3300);

        upd(32'h3030, 1'b1, 32'h3400);
        chk_pred("alias_evict", 1'b0, 32'h0);
        jump(32'h3030);
        chk_pred("alias_alloc", 1'b1, 32'h3400);

        reset = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h3000; upd_taken = 1'b1; upd_target = 32'h3500;
        tick();
        reset = 1'b0; upd_valid = 1'b0;
        chk("rst2_pc", pc, 32'h3000);
        chk_pred("rst2_discard", 1'b0, 32'h0);
        jump(32'h3030);
        chk_pred("rst2_cleared", 1'b0, 32'h0);

        jump(32'hFFFF_FFFC);
        chk("wrap_start", pc, 32'hFFFF_FFFC);
        chk("wrap_npc", pred_npc, 32'h0000_0000);
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("wrap", pc, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
